// File: rtl/instr_prefetch_queue_if.sv
// Bundle between the prefetch queue, the instruction memory and the instruction
// register. The prefetch queue side uses "master"; the environment uses "slave".
interface instr_prefetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  // Memory side: mem_rd/mem_addr are a fire-and-forget strobe, and mem_rdata
  // is valid exactly one cycle after mem_rd.
  logic        mem_rd;
  logic [63:0] mem_addr;
  logic [31:0] mem_rdata;

  // Consumer side: a transfer happens on a cycle where ir_valid && ir_ready.
  // ir_valid never depends on ir_ready, and ir_ready without ir_valid is ignored.
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_instr;
  logic [63:0] ir_pc;

  logic        redirect;
  logic [63:0] redirect_pc;
  logic [CW-1:0] count;

  modport master (
    output mem_rd, mem_addr, ir_valid, ir_instr, ir_pc, count,
    input  mem_rdata, ir_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_rd, mem_addr, ir_valid, ir_instr, ir_pc, count,
    output mem_rdata, ir_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: runs ahead of the control FSM, fetching from a
// 1-cycle-latency instruction RAM into a small FIFO of {instr, pc} entries.
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] PC_RESET = 64'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  instr_prefetch_queue_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [63:0]   fetch_pc;
  logic [63:0]   issued_pc;
  logic          inflight;
  logic          kill;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic [31:0]   instr_q [DEPTH];
  logic [63:0]   pc_q    [DEPTH];

  logic          issue;
  logic          push;
  logic          pop;
  logic [CW:0]   occupancy;

  always_comb begin
    occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight};
    // Reserving a slot for the in-flight read is what makes overflow impossible.
    issue     = !reset && !bus.redirect && (occupancy < (CW + 1)'(DEPTH));
    pop       = (count_q != '0) && bus.ir_ready;
    // A read returning during a redirect (or one already marked killed) is stale.
    push      = inflight && !kill && !bus.redirect;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc  <= PC_RESET;
      issued_pc <= '0;
      inflight  <= 1'b0;
      kill      <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      inflight <= issue;
      kill     <= bus.redirect;

      if (issue) begin
        fetch_pc  <= fetch_pc + 64'd4;
        issued_pc <= fetch_pc;
      end
      if (bus.redirect) begin
        fetch_pc <= bus.redirect_pc & ~64'h3;
      end

      if (push) begin
        instr_q[wr_ptr] <= bus.mem_rdata;
        pc_q[wr_ptr]    <= issued_pc;
        wr_ptr          <= wr_ptr + PW'(1);
      end

      // A pop in the redirect cycle is simply absorbed by the flush.
      if (bus.redirect) begin
        rd_ptr  <= wr_ptr;
        count_q <= '0;
      end else begin
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  assign bus.mem_rd   = issue;
  assign bus.mem_addr = fetch_pc;
  assign bus.ir_valid = (count_q != '0);
  assign bus.ir_instr = instr_q[rd_ptr];
  assign bus.ir_pc    = pc_q[rd_ptr];
  assign bus.count    = count_q;
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: a per-cycle vector table covering
// fill, drain, redirects and mid-operation reset, plus an address-wrap sequence.
module tb_instr_prefetch_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instr_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

  instr_prefetch_queue #(.DEPTH(DEPTH), .PC_RESET(64'h0)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory: contents are pc | 32'hA000_0000.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= bus.mem_addr[31:0] | 32'hA000_0000;
    else            bus.mem_rdata <= 32'hDEAD_BEEF;
  end

  typedef struct {
    logic        rst;
    logic        ready;
    logic        redir;
    logic [63:0] rpc;
    logic        e_rd;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [2:0]  e_cnt;
  } vec_t;

  localparam int NVEC = 31;
  vec_t vecs [NVEC];
  int   total = 0;
  int   bad   = 0;
  int   row   = -1;

  function automatic vec_t mk(logic r, logic rdy, logic rd, logic [63:0] rp,
                              logic erd, logic [63:0] ea, logic ev,
                              logic [63:0] epc, logic [2:0] ec);
    vec_t v;
    v.rst = r;  v.ready = rdy; v.redir = rd;  v.rpc = rp;
    v.e_rd = erd; v.e_addr = ea; v.e_valid = ev; v.e_pc = epc; v.e_cnt = ec;
    return v;
  endfunction

  function automatic logic [31:0] exp_instr(logic [63:0] pc);
    return pc[31:0] | 32'hA000_0000;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Count must never exceed DEPTH.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if (bus.count > 3'(DEPTH)) begin
        bad++;
        $display("FAIL overflow actual=%0d required<=%0d", bus.count, DEPTH);
      end
    end
  end

  initial begin
    // Cycle-by-cycle vectors; row 0 is the first cycle after reset release.
    //               rst rdy rdr rpc          rd  addr        v  pc         cnt
    vecs[0]  = mk(0, 1, 0, 64'h0,   1, 64'h0,   0, 64'h0,   3'd0);
    vecs[1]  = mk(0, 1, 0, 64'h0,   1, 64'h4,   0, 64'h0,   3'd0);
    vecs[2]  = mk(0, 1, 0, 64'h0,   1, 64'h8,   1, 64'h0,   3'd1);
    vecs[3]  = mk(0, 1, 0, 64'h0,   1, 64'hC,   1, 64'h4,   3'd1);
    vecs[4]  = mk(0, 1, 1, 64'h43,  0, 64'h10,  1, 64'h8,   3'd1);
    vecs[5]  = mk(0, 1, 0, 64'h0,   1, 64'h40,  0, 64'h0,   3'd0);
    vecs[6]  = mk(0, 1, 0, 64'h0,   1, 64'h44,  0, 64'h0,   3'd0);
    vecs[7]  = mk(0, 1, 0, 64'h0,   1, 64'h48,  1, 64'h40,  3'd1);
    vecs[8]  = mk(0, 1, 0, 64'h0,   1, 64'h4C,  1, 64'h44,  3'd1);
    vecs[9]  = mk(0, 1, 1, 64'h10,  0, 64'h50,  1, 64'h48,  3'd1);
    vecs[10] = mk(0, 1, 0, 64'h0,   1, 64'h10,  0, 64'h0,   3'd0);
    vecs[11] = mk(0, 1, 1, 64'h40,  0, 64'h14,  0, 64'h0,   3'd0);
    vecs[12] = mk(0, 1, 0, 64'h0,   1, 64'h40,  0, 64'h0,   3'd0);
    vecs[13] = mk(0, 1, 0, 64'h0,   1, 64'h44,  0, 64'h0,   3'd0);
    vecs[14] = mk(0, 1, 0, 64'h0,   1, 64'h48,  1, 64'h40,  3'd1);
    vecs[15] = mk(0, 0, 1, 64'h200, 0, 64'h4C,  1, 64'h44,  3'd1);
    vecs[16] = mk(0, 0, 1, 64'h300, 0, 64'h200, 0, 64'h0,   3'd0);
    vecs[17] = mk(0, 0, 0, 64'h0,   1, 64'h300, 0, 64'h0,   3'd0);
    vecs[18] = mk(0, 0, 0, 64'h0,   1, 64'h304, 0, 64'h0,   3'd0);
    vecs[19] = mk(0, 0, 0, 64'h0,   1, 64'h308, 1, 64'h300, 3'd1);
    vecs[20] = mk(0, 0, 0, 64'h0,   1, 64'h30C, 1, 64'h300, 3'd2);
    vecs[21] = mk(1, 0, 0, 64'h0,   0, 64'h310, 1, 64'h300, 3'd3);
    vecs[22] = mk(0, 0, 0, 64'h0,   1, 64'h0,   0, 64'h0,   3'd0);
    vecs[23] = mk(0, 0, 0, 64'h0,   1, 64'h4,   0, 64'h0,   3'd0);
    vecs[24] = mk(0, 0, 0, 64'h0,   1, 64'h8,   1, 64'h0,   3'd1);
    vecs[25] = mk(0, 0, 0, 64'h0,   1, 64'hC,   1, 64'h0,   3'd2);
    vecs[26] = mk(0, 0, 0, 64'h0,   0, 64'h10,  1, 64'h0,   3'd3);
    vecs[27] = mk(0, 0, 0, 64'h0,   0, 64'h10,  1, 64'h0,   3'd4);
    vecs[28] = mk(0, 0, 0, 64'h0,   0, 64'h10,  1, 64'h0,   3'd4);
    vecs[29] = mk(0, 1, 0, 64'h0,   0, 64'h10,  1, 64'h0,   3'd4);
    vecs[30] = mk(0, 1, 0, 64'h0,   1, 64'h10,  1, 64'h4,   3'd3);

    // Clock/reset.
    bus.ir_ready    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 64'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_count", 64'(bus.count), 64'h0);
    chk("rst_valid", 64'(bus.ir_valid), 64'h0);
    chk("rst_instr", 64'(bus.ir_instr), 64'h0);
    chk("rst_pc", bus.ir_pc, 64'h0);
    chk("rst_addr", bus.mem_addr, 64'h0);

    for (int i = 0; i < NVEC; i++) begin
      row             = i;
      rst             = vecs[i].rst;
      bus.ir_ready    = vecs[i].ready;
      bus.redirect    = vecs[i].redir;
      bus.redirect_pc = vecs[i].rpc;
      @(negedge clk);
      chk("mem_rd", 64'(bus.mem_rd), 64'(vecs[i].e_rd));
      chk("mem_addr", bus.mem_addr, vecs[i].e_addr);
      chk("ir_valid", 64'(bus.ir_valid), 64'(vecs[i].e_valid));
      chk("count", 64'(bus.count), 64'(vecs[i].e_cnt));
      if (vecs[i].e_valid) begin
        chk("ir_pc", bus.ir_pc, vecs[i].e_pc);
        chk("ir_instr", 64'(bus.ir_instr), 64'(exp_instr(vecs[i].e_pc)));
      end
      next_cycle();
    end

    // Address wrap at 2^64; redirect_pc low bits are discarded.
    row             = 100;
    rst             = 1'b0;
    bus.ir_ready    = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    @(negedge clk);
    chk("wrap_no_issue", 64'(bus.mem_rd), 64'h0);
    next_cycle();
    row          = 101;
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("wrap_rd", 64'(bus.mem_rd), 64'h1);
    chk("wrap_addr0", bus.mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    next_cycle();
    row = 102;
    @(negedge clk);
    chk("wrap_addr1", bus.mem_addr, 64'h0);
    chk("wrap_empty", 64'(bus.ir_valid), 64'h0);
    next_cycle();
    row = 103;
    @(negedge clk);
    chk("wrap_valid", 64'(bus.ir_valid), 64'h1);
    chk("wrap_pc0", bus.ir_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_instr0", 64'(bus.ir_instr), 64'hFFFF_FFFC);
    bus.ir_ready = 1'b1;
    next_cycle();
    row = 104;
    @(negedge clk);
    chk("wrap_pc1", bus.ir_pc, 64'h0);
    chk("wrap_instr1", 64'(bus.ir_instr), 64'hA000_0000);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
